// File: rtl/lfsr_stream_cipher.sv
// Word-oriented stream cipher: a Galois LFSR generates DATA_W keystream bits
// per word (LSB first), which are XORed with the input word behind valid/ready handshakes.
module lfsr_stream_cipher #(
  parameter int                DATA_W       = 8,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              ks_bit
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, GEN, OUT} state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ks_q, ks_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // ks_d already contains the bit emitted this cycle, so the final GEN step
  // can produce the output word without an extra cycle.
  assign lfsr_d = lfsr_step(lfsr_q);
  assign ks_d   = ks_q | (DATA_W'(lfsr_q[0]) << cnt_q);

  assign in_ready  = (state_q == IDLE) && !seed_load;
  assign busy      = (state_q != IDLE);
  assign ks_bit    = lfsr_q[0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_DEFAULT;
      cnt_q       <= '0;
      data_q      <= '0;
      ks_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            // A zero seed would lock the LFSR at zero forever.
            lfsr_q <= (seed == '0) ? SEED_DEFAULT : seed;
          end else if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= '0;
            ks_q    <= '0;
            state_q <= GEN;
          end
        end
        GEN: begin
          lfsr_q <= lfsr_d;
          ks_q   <= ks_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= '0;
            out_data_q  <= data_q ^ ks_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher: directed scenarios plus random
// words and seeds against a behavioural keystream model.
module tb_lfsr_stream_cipher;

  logic        clk = 1'b0;
  logic        nrst;
  logic        seed_load;
  logic [15:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        ks_bit;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state;

  lfsr_stream_cipher #(
    .DATA_W(8), .LFSR_W(16), .TAPS(16'hB400), .SEED_DEFAULT(16'hACE1)
  ) dut (
    .clk(clk), .nrst(nrst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ks_bit(ks_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference keystream: take the state's low bit, halve the state and fold
  // in the tap mask whenever the dropped bit was one.
  task automatic model_word(output logic [7:0] ks);
    int b;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      b = m_state % 2;
      ks[i] = b[0];
      m_state = (m_state / 2) ^ (b != 0 ? 32'hB400 : 32'h0);
    end
  endtask

  task automatic load_seed(input string tag, input logic [15:0] s);
    seed_load = 1'b1;
    seed = s;
    #1;
    check({tag, "_in_ready_lo"}, in_ready, 1'b0);
    cycle();
    seed_load = 1'b0;
    m_state = (s == 16'h0) ? 32'hACE1 : int'(s);
  endtask

  // Sends one word; hold = cycles of out_ready low (with a competing in_valid),
  // gen_pulse >= 0 pulses seed_load at that GEN cycle.
  task automatic send(input string tag, input logic [7:0] d, input int hold,
                      input int gen_pulse, output logic [7:0] got);
    logic [7:0] ks;
    logic [7:0] held;
    int lat;
    in_valid = 1'b1;
    in_data = d;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      seed_load = (lat == gen_pulse);
      seed = 16'h1234;
      cycle();
      lat++;
    end
    seed_load = 1'b0;
    check({tag, "_latency"}, lat, 8);
    model_word(ks);
    got = out_data;
    check({tag, "_data"}, out_data, d ^ ks);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data = 8'hAA;
      cycle();
      check({tag, "_bp_valid"}, out_valid, 1'b1);
      check({tag, "_bp_stable"}, out_data, held);
      check({tag, "_bp_in_ready"}, in_ready, 1'b0);
      check({tag, "_bp_busy"}, busy, 1'b1);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_done_valid"}, out_valid, 1'b0);
    check({tag, "_done_busy"}, busy, 1'b0);
    #1;
    check({tag, "_done_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] ks;
    logic [7:0] d;
    logic [15:0] s;
    int lat;
    nrst = 1'b0; seed_load = 1'b0; seed = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    m_state = 32'hACE1;
    cycle(); cycle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ks_bit", ks_bit, 1'b1);
    check("rst_lfsr", dut.lfsr_q, 16'hACE1);
    nrst = 1'b1;
    cycle();

    // Keystream from reset
    send("ks1", 8'h00, 0, -1, got);
    check("ks1_const", got, 8'hE1);
    check("ks1_lfsr", dut.lfsr_q, 16'hC2C4);
    send("ks2", 8'h00, 0, -1, got);
    check("ks2_const", got, 8'hC4);

    // Round trip
    load_seed("rt_seed0", 16'hACE1);
    send("rt_enc", 8'h55, 0, -1, got);
    check("rt_enc_const", got, 8'hB4);
    load_seed("rt_seed1", 16'hACE1);
    send("rt_dec", 8'hB4, 0, -1, got);
    check("rt_dec_const", got, 8'h55);

    // Zero and custom seed
    load_seed("zs", 16'h0000);
    send("zs_w", 8'h00, 0, -1, got);
    check("zs_const", got, 8'hE1);
    load_seed("cs", 16'h1234);
    send("cs_w", 8'h00, 0, -1, got);
    check("cs_const", got, 8'h34);

    // Backpressure with a competing word held during OUT
    send("bp", 8'h3C, 5, -1, got);

    // seed_load together with in_valid in IDLE
    seed_load = 1'b1; seed = 16'h1234; in_valid = 1'b1; in_data = 8'h00;
    #1;
    check("sim_in_ready_lo", in_ready, 1'b0);
    cycle();
    seed_load = 1'b0;
    m_state = 32'h1234;
    check("sim_not_accepted", busy, 1'b0);
    send("sim_w", 8'h00, 0, -1, got);
    check("sim_const", got, 8'h34);

    // seed_load during GEN is ignored
    send("gen_seed", 8'h96, 0, 2, got);

    // Async reset mid-GEN
    in_valid = 1'b1; in_data = 8'h00;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    #2 nrst = 1'b0;
    #1;
    check("arst_gen_busy", busy, 1'b0);
    check("arst_gen_valid", out_valid, 1'b0);
    check("arst_gen_lfsr", dut.lfsr_q, 16'hACE1);
    cycle();
    nrst = 1'b1;
    m_state = 32'hACE1;
    cycle();
    send("arst_w", 8'h00, 0, -1, got);
    check("arst_const", got, 8'hE1);

    // Async reset while holding a result in OUT
    in_valid = 1'b1; in_data = 8'h11;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    check("arst_out_reached", out_valid, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 8'h00);
    cycle();
    nrst = 1'b1;
    m_state = 32'hACE1;
    cycle();

    // Random words, seeds and backpressure
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
        load_seed("rnd_seed", s);
      end
      check("rnd_ks_bit", ks_bit, m_state[0]);
      d = 8'($urandom_range(0, 255));
      send("rnd", d, int'($urandom_range(0, 3)), -1, got);
    end

    // Random round trip: the same seed decrypts what it encrypted
    s = 16'($urandom_range(1, 65535));
    d = 8'($urandom_range(0, 255));
    load_seed("rrt_s0", s);
    send("rrt_enc", d, 0, -1, got);
    ks = got;
    load_seed("rrt_s1", s);
    send("rrt_dec", ks, 0, -1, got);
    check("rrt_plain", got, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
